// File: rtl/systola_pkg.sv
// Shared constants and types for the input-memory arbiter slice.
package systola_pkg;

    localparam logic [1:0] ID_HOST = 2'd0;
    localparam logic [1:0] ID_ACT  = 2'd1;
    localparam logic [1:0] ID_WGT  = 2'd2;

    localparam int RD_LAT = 2;

    typedef enum logic {
        LAST_ACT = 1'b0,
        LAST_WGT = 1'b1
    } rr_last_e;

    // Out of reset the weight port counts as last served, so act wins the first contention.
    localparam rr_last_e RR_RESET = LAST_WGT;

    typedef struct packed {
        logic       valid;
        logic [1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/inpmem_arb_if.sv
// Request/grant, read-return and SRAM pin bundle of the input-memory arbiter.
interface inpmem_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              h_req;
    logic              h_we;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic              h_gnt;
    logic              a_gnt;
    logic              w_gnt;
    logic              rd_valid;
    logic [1:0]        rd_id;
    logic [DATA_W-1:0] rdata;
    logic              mem_cen;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output h_req, h_we, h_addr, h_wdata, a_req, a_addr, w_req, w_addr, mem_q,
        input  h_gnt, a_gnt, w_gnt, rd_valid, rd_id, rdata, mem_cen, mem_wen, mem_a, mem_d
    );

    modport slave (
        input  h_req, h_we, h_addr, h_wdata, a_req, a_addr, w_req, w_addr, mem_q,
        output h_gnt, a_gnt, w_gnt, rd_valid, rd_id, rdata, mem_cen, mem_wen, mem_a, mem_d
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way fetch arbiter, bit 0 = act, bit 1 = wgt.
// INPMEM_ARB_RR_EN selects round-robin; otherwise fixed priority act over wgt.
module rr_arb2
    import systola_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
`ifdef INPMEM_ARB_RR_EN
    rr_last_e last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == LAST_ACT) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            last_d = LAST_ACT;
        end else if (gnt_o[1]) begin
            last_d = LAST_WGT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q <= RR_RESET;
        end else begin
            last_q <= last_d;
        end
    end
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk & rstn;
    assign gnt_o          = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
`endif
endmodule

// File: rtl/inpmem_arb.sv
// Three-port arbiter in front of one INPMEM SRAM: host has absolute priority,
// act/wgt share rr_arb2; reads return a fixed RD_LAT cycles after the grant.
module inpmem_arb
    import systola_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rstn,
    inpmem_arb_if.slave   bus
);
    logic [1:0]        fetch_req;
    logic [1:0]        fetch_gnt;
    logic              h_gnt;
    logic              any_gnt;
    logic              wr_gnt;
    logic              rd_gnt;
    logic [1:0]        gnt_id;
    logic [ADDR_W-1:0] sel_addr;
    logic              mem_cen_q, mem_cen_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [DATA_W-1:0] mem_d_q, mem_d_d;
    rd_tag_t           tag_d;
    rd_tag_t           pipe_q [RD_LAT];

    assign h_gnt     = rstn & bus.h_req;
    assign fetch_req = {bus.w_req, bus.a_req} & {2{rstn & ~bus.h_req}};

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rstn  (rstn),
        .req_i (fetch_req),
        .gnt_o (fetch_gnt)
    );

    assign bus.h_gnt = h_gnt;
    assign bus.a_gnt = fetch_gnt[0];
    assign bus.w_gnt = fetch_gnt[1];

    always_comb begin
        any_gnt  = h_gnt | (|fetch_gnt);
        wr_gnt   = h_gnt & bus.h_we;
        rd_gnt   = any_gnt & ~wr_gnt;
        gnt_id   = ID_HOST;
        sel_addr = bus.h_addr;
        if (fetch_gnt[0]) begin
            gnt_id   = ID_ACT;
            sel_addr = bus.a_addr;
        end else if (fetch_gnt[1]) begin
            gnt_id   = ID_WGT;
            sel_addr = bus.w_addr;
        end
        mem_cen_d    = ~any_gnt;
        mem_wen_d    = ~wr_gnt;
        mem_a_d      = any_gnt ? sel_addr : mem_a_q;
        mem_d_d      = wr_gnt ? bus.h_wdata : mem_d_q;
        tag_d.valid  = rd_gnt;
        tag_d.id     = rd_gnt ? gnt_id : ID_HOST;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_cen_q <= 1'b1;
            mem_wen_q <= 1'b1;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            mem_cen_q <= mem_cen_d;
            mem_wen_q <= mem_wen_d;
            mem_a_q   <= mem_a_d;
            mem_d_q   <= mem_d_d;
            pipe_q[0] <= tag_d;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.mem_cen  = mem_cen_q;
    assign bus.mem_wen  = mem_wen_q;
    assign bus.mem_a    = mem_a_q;
    assign bus.mem_d    = mem_d_q;
    // SRAM output is valid only in the return cycle; mask it elsewhere.
    assign bus.rd_valid = pipe_q[RD_LAT-1].valid;
    assign bus.rd_id    = pipe_q[RD_LAT-1].id;
    assign bus.rdata    = pipe_q[RD_LAT-1].valid ? bus.mem_q : '0;
endmodule
